mdu_ctrl: RTL

Multi-cycle multiply/divide unit controller for the P6 pipeline. It sits in the E stage beside the ALU and owns the HI/LO registers. It sequences MULT/MULTU/DIV/DIVU with a fixed latency and handles MTHI/MTLO writes. It exposes `busy` so the hazard unit can stall D-stage MDU instructions, and it provides HI/LO readback for MFHI/MFLO.

---
 rtl/mdu_ctrl_pkg.sv | 21 ++
 rtl/mdu_calc.sv | 25 ++
 rtl/mdu_ctrl.sv | 52 +++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: MDU op encodings, FSM states, default latencies and op-class helpers
package mdu_ctrl_pkg;
  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  function automatic logic is_mul(input logic [3:0] op);
    return op == MDU_MULT || op == MDU_MULTU;
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit multiply / divide result with divide-by-zero flag
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] res,
  output logic        div_by_zero
);
  logic sg;
  logic [63:0] prod;
  logic [31:0] ua, ub, d, q, r;
  always_comb begin
    sg = op == MDU_MULT || op == MDU_DIV;
    prod = {{32{sg & a[31]}}, a} * {{32{sg & b[31]}}, b};
    ua = sg && a[31] ? -a : a;
    ub = sg && b[31] ? -b : b;
    d = ub == '0 ? 32'd1 : ub;
    q = ua / d;
    r = ua % d;
    div_by_zero = is_div(op) && b == '0;
    res = is_div(op) ? {sg && a[31] ? -r : r, sg && (a[31] ^ b[31]) ? -q : q} : prod;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency MULT/DIV sequencer owning HI/LO, with MTHI/MTLO and readback
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic [31:0] mdu_rdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  mdu_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [63:0] res, pend;
  logic dz, pend_dz, idle_start, go, done;
  mdu_calc u_calc (.a(a), .b(b), .op(mdu_op), .res(res), .div_by_zero(dz));
  assign idle_start = state == IDLE && start;
  assign go = idle_start && (is_mul(mdu_op) || is_div(mdu_op));
  assign done = state == BUSY && cnt == CW'(1);
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb state_nx = go ? BUSY : done ? IDLE : state;
  always_comb begin
    busy = state == BUSY;
    mdu_rdata = rd_hi ? hi : lo;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      pend <= '0;
      pend_dz <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (go) begin
        cnt <= is_mul(mdu_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        pend <= res;
        pend_dz <= dz;
      end else if (state == BUSY) cnt <= cnt - 1'b1;
      if (done && !pend_dz) {hi, lo} <= pend;
      if (idle_start && mdu_op == MDU_MTHI) hi <= a;
      if (idle_start && mdu_op == MDU_MTLO) lo <= a;
    end
endmodule
